// File: rtl/event_buf_reader.sv
// event_buf_reader: walks the ADC event buffer rows 63..0 after an L0 capture
// and streams each row as DW-bit words behind a single header word.
module event_buf_reader #(
  parameter int unsigned ROW_W  = 768,
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              evt_ready,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [ROW_W-1:0]  buf_data,
  output logic [DW-1:0]     m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned WPR   = ROW_W / DW;
  localparam int unsigned K_W   = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    FETCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t             state_q;
  logic [15:0]        evt_num;
  logic [K_W-1:0]     k_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ROW_W-1:0]   row_q;

  logic [DW-1:0]      hdr_c;
  logic [K_W-1:0]     next_k_c;
  logic               capture_c;
  logic               last_word_c;
  logic               last_row_c;

  // Header word, next slice index and the FETCH capture strobe
  always_comb begin
    hdr_c       = DW'({8'hE5, drop_cnt, evt_num});
    next_k_c    = k_q + K_W'(1);
    capture_c   = (state_q == FETCH) && (wait_cnt == CNT_W'(RD_LAT));
    last_word_c = (k_q == K_W'(WPR - 1));
    last_row_c  = (read_addr == '0);
  end

  // Row register: loaded only on the capture cycle, otherwise held
  always_ff @(posedge rd_clk) begin
    if (capture_c) begin
      row_q <= buf_data;
    end
  end

  // Reader FSM with registered stream outputs, address and counters
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      read_addr <= ADDR_W'(DEPTH - 1);
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      busy      <= 1'b0;
      drop_cnt  <= 8'h00;
      evt_num   <= 16'h0000;
      k_q       <= '0;
      wait_cnt  <= '0;
    end else begin
      if (evt_ready && (state_q != IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (evt_ready) begin
            state_q   <= HDR;
            busy      <= 1'b1;
            read_addr <= ADDR_W'(DEPTH - 1);
            m_valid   <= 1'b1;
            m_last    <= 1'b0;
            m_data    <= hdr_c;
          end
        end
        HDR: begin
          if (m_ready) begin
            state_q  <= FETCH;
            m_valid  <= 1'b0;
            wait_cnt <= '0;
          end
        end
        FETCH: begin
          if (capture_c) begin
            state_q <= SEND;
            k_q     <= '0;
            m_valid <= 1'b1;
            m_data  <= buf_data[DW-1:0];
            m_last  <= last_row_c && (WPR == 1);
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        SEND: begin
          if (m_ready) begin
            if (!last_word_c) begin
              k_q    <= next_k_c;
              m_data <= row_q[DW*next_k_c +: DW];
              m_last <= last_row_c && (next_k_c == K_W'(WPR - 1));
            end else if (!last_row_c) begin
              read_addr <= read_addr - ADDR_W'(1);
              state_q   <= FETCH;
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              wait_cnt  <= '0;
            end else begin
              state_q   <= IDLE;
              busy      <= 1'b0;
              m_valid   <= 1'b0;
              m_last    <= 1'b0;
              evt_num   <= evt_num + 16'd1;
              read_addr <= ADDR_W'(DEPTH - 1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_buf_reader.sv
// tb_event_buf_reader: directed checks of the event buffer reader with
// behavioural buffer models at read latency 1 (dut) and 2 (dut2).
module tb_event_buf_reader;

  localparam int EVT_LEN = 1537;
  localparam int NONE    = -1;

  logic         clk;
  logic         rst;
  logic         evt_x;
  logic         rdy;
  logic         sel;

  logic [5:0]   ra1, ra2;
  logic [767:0] b1, b2a, b2;
  logic [31:0]  d1, d2;
  logic         v1, v2, l1, l2, bz1, bz2;
  logic [7:0]   dc1, dc2;

  logic [31:0]  o_data;
  logic         o_valid, o_last, o_busy;
  logic [7:0]   o_drop;
  logic [5:0]   o_addr;

  int total = 0;
  int bad   = 0;
  int lat;

  event_buf_reader #(.RD_LAT(1)) dut (
    .rd_clk(clk), .rst(rst), .evt_ready(evt_x & ~sel), .read_addr(ra1),
    .buf_data(b1), .m_data(d1), .m_valid(v1), .m_ready(rdy), .m_last(l1),
    .busy(bz1), .drop_cnt(dc1)
  );

  event_buf_reader #(.RD_LAT(2)) dut2 (
    .rd_clk(clk), .rst(rst), .evt_ready(evt_x & sel), .read_addr(ra2),
    .buf_data(b2), .m_data(d2), .m_valid(v2), .m_ready(rdy), .m_last(l2),
    .busy(bz2), .drop_cnt(dc2)
  );

  assign o_data  = sel ? d2  : d1;
  assign o_valid = sel ? v2  : v1;
  assign o_last  = sel ? l2  : l1;
  assign o_busy  = sel ? bz2 : bz1;
  assign o_drop  = sel ? dc2 : dc1;
  assign o_addr  = sel ? ra2 : ra1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [767:0] row_of(input logic [5:0] a);
    logic [767:0] r;
    r = '0;
    for (int k = 0; k < 24; k++) r[32*k +: 32] = {8'(a), 8'(k), 16'hC0DE};
    return r;
  endfunction

  // Buffer models: one and two clocks from address to data
  always @(posedge clk) begin
    b1  <= row_of(ra1);
    b2a <= row_of(ra2);
    b2  <= b2a;
  end

  function automatic logic [31:0] exp_word(input int i, input logic [31:0] hdr);
    int j;
    if (i == 0) return hdr;
    j = i - 1;
    return {8'(63 - j / 24), 8'(j % 24), 16'hC0DE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    evt_x = 1'b1;
    @(negedge clk);
    evt_x = 1'b0;
  endtask

  // Consume one event starting at the negedge where the header is visible.
  task automatic run_event(input logic [31:0] hdr, input int prob_low, input int drops,
                           input int dgap, input bit end_pulse, input int abort_at,
                           output int first_lat);
    int          i = 0;
    int          cyc = 0;
    int          dleft = drops;
    int          hx = 0;
    bit          seen1 = 1'b0;
    bit          pstall = 1'b0;
    bit          aborted = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    first_lat = -1;
    while (i < EVT_LEN && cyc < 20000) begin
      if (pstall) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", o_data, pd);
        chk("stall_last", 32'(o_last), 32'(pl));
      end
      if (o_valid) begin
        chk("word", o_data, exp_word(i, hdr));
        chk("last", 32'(o_last), 32'(i == EVT_LEN - 1));
        if (i == 1 && !seen1) begin
          seen1 = 1'b1;
          first_lat = cyc - hx;
        end
      end
      if (abort_at != NONE && i == abort_at && o_valid) begin
        rdy = 1'b0;
        aborted = 1'b1;
        break;
      end
      rdy = (prob_low == 0) ? 1'b1 : ($urandom_range(99) >= 32'(prob_low));
      evt_x = 1'b0;
      if (dleft > 0 && (cyc % dgap) == 1) begin
        evt_x = 1'b1;
        dleft--;
      end
      if (end_pulse && o_valid && rdy && i == EVT_LEN - 1) evt_x = 1'b1;
      pstall = o_valid && !rdy;
      pd = o_data;
      pl = o_last;
      if (o_valid && rdy) begin
        if (i == 0) hx = cyc;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    evt_x = 1'b0;
    if (!aborted && i < EVT_LEN) chk("event_timeout", 32'(i), 32'(EVT_LEN));
  endtask

  initial begin
    rst = 1'b1; evt_x = 1'b0; rdy = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_drop", 32'(o_drop), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd63);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(o_valid), 32'd0);

    // Event 0, no backpressure
    pulse();
    chk("hdr_busy", 32'(o_busy), 32'd1);
    run_event(32'hE500_0000, 0, 0, 2, 1'b0, NONE, lat);
    chk("lat_rd1", 32'(lat), 32'd3);
    chk("end_busy", 32'(o_busy), 32'd0);
    chk("end_valid", 32'(o_valid), 32'd0);
    chk("end_addr", 32'(o_addr), 32'd63);

    // Event 1 with random backpressure and three drops mid-event
    pulse();
    run_event(32'hE500_0001, 40, 3, 300, 1'b0, NONE, lat);
    chk("drop3", 32'(o_drop), 32'd3);

    // Event 2 with evt_ready on the final transfer, then accepted in first IDLE cycle
    pulse();
    run_event(32'hE503_0002, 0, 0, 2, 1'b1, NONE, lat);
    chk("simul_busy", 32'(o_busy), 32'd0);
    chk("simul_drop", 32'(o_drop), 32'd4);
    pulse();

    // Event 3 with 300 drops: saturation
    run_event(32'hE504_0003, 0, 300, 2, 1'b0, NONE, lat);
    chk("drop_sat", 32'(o_drop), 32'hFF);

    // Event 4 aborted by reset at r=30, k=10 under stall
    pulse();
    run_event(32'hE5FF_0004, 30, 0, 2, 1'b0, (63 - 30) * 24 + 10 + 1, lat);
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_addr", 32'(o_addr), 32'd63);
    chk("mid_rst_drop", 32'(o_drop), 32'd0);
    chk("mid_rst_last", 32'(o_last), 32'd0);
    @(negedge clk);

    pulse();
    run_event(32'hE500_0000, 0, 0, 2, 1'b0, NONE, lat);

    // Event number wrap
    force dut.evt_num = 16'hFFFF;
    @(negedge clk);
    release dut.evt_num;
    @(negedge clk);
    pulse();
    run_event(32'hE500_FFFF, 0, 0, 2, 1'b0, NONE, lat);
    pulse();
    run_event(32'hE500_0000, 0, 0, 2, 1'b0, 0, lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Read latency 2 instance
    sel = 1'b1;
    @(negedge clk);
    pulse();
    run_event(32'hE500_0000, 0, 0, 2, 1'b0, NONE, lat);
    chk("lat_rd2", 32'(lat), 32'd4);
    chk("rd2_busy", 32'(o_busy), 32'd0);
    chk("rd2_drop", 32'(o_drop), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
